fir_interp_poly: RTL and testbench

//  Parametrised L-times polyphase interpolating FIR for the DAC path, multi-channel, single time-shared MAC.

---
 rtl/fir_interp_pkg.sv | 45 ++++
 rtl/fir_mac_sat.sv | 33 +++
 rtl/fir_interp_poly.sv | 158 +++++++++++++++
 tb/tb_fir_interp_poly.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_interp_pkg.sv
// Shared types and helpers for the polyphase interpolating FIR:
// FSM state encoding, default linear-interpolation coefficients,
// accumulator width and the round-half-up / saturate step.
package fir_interp_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MAC  = 2'd1,
      ST_EMIT = 2'd2
   } state_t;

   // Accumulator wide enough for taps full-scale products without wrap.
   function automatic int acc_width(input int data_w, input int coef_w, input int taps);
      return data_w + coef_w + $clog2(taps);
   endfunction

   localparam int ACC_W = acc_width(24, 16, 8);

   // Linear interpolation: tap0 weights (L-p)/L, tap1 weights p/L, rest 0.
   // A weight of exactly 1.0 is not representable in Q1.x and clips to max.
   function automatic logic signed [31:0] def_coef(input int p, input int tap,
                                                   input int l, input int coef_w);
      longint one, num, v;
      one = longint'(1) << (coef_w - 1);
      if (tap == 0)      num = longint'(l - p) * one;
      else if (tap == 1) num = longint'(p) * one;
      else               return 32'sd0;
      v = (2 * num + l) / (2 * l);
      if (v >= one) v = one - 1;
      return 32'(v);
   endfunction

   // Drop shift fractional bits with round-half-up, clamp to out_w signed.
   function automatic logic signed [63:0] round_sat(input logic signed [63:0] acc,
                                                    input int shift, input int out_w);
      logic signed [63:0] r, maxv, minv;
      r    = (acc + (64'sd1 <<< (shift - 1))) >>> shift;
      maxv = (64'sd1 <<< (out_w - 1)) - 64'sd1;
      minv = -(64'sd1 <<< (out_w - 1));
      if (r > maxv)      return maxv;
      else if (r < minv) return minv;
      else               return r;
   endfunction

endpackage

// File: rtl/fir_mac_sat.sv
// Time-shared multiply-accumulate with rounded and saturated output.
// 'first' restarts the sum with the current product; y follows acc.
module fir_mac_sat
   import fir_interp_pkg::*;
#(
   parameter int DATA_W         = 24,
   parameter int COEF_W         = 16,
   parameter int TAPS_PER_PHASE = 8
) (
   input  logic                     clk,
   input  logic                     en,
   input  logic                     first,
   input  logic signed [DATA_W-1:0] x,
   input  logic signed [COEF_W-1:0] h,
   output logic signed [DATA_W-1:0] y
);

   localparam int PROD_W = DATA_W + COEF_W;
   localparam int AW     = acc_width(DATA_W, COEF_W, TAPS_PER_PHASE);

   logic signed [PROD_W-1:0] prod;
   logic signed [AW-1:0]     acc;

   assign prod = PROD_W'(x) * PROD_W'(h);

   // Accumulate one tap per enabled cycle; first tap overwrites old sum.
   always_ff @(posedge clk) begin
      if (en) acc <= first ? AW'(prod) : acc + AW'(prod);
   end

   assign y = DATA_W'(round_sat(64'(acc), COEF_W - 1, DATA_W));

endmodule

// File: rtl/fir_interp_poly.sv
// L-times polyphase interpolating FIR, channel-interleaved, one shared MAC.
// Optional build macro FIR_INTERP_COEF_WR_EN adds a coefficient write port
// (coef_we/coef_addr/coef_wdata); otherwise coefficients are fixed defaults.
module fir_interp_poly
   import fir_interp_pkg::*;
#(
   parameter int  DATA_W         = 24,
   parameter int  COEF_W         = 16,
   parameter int  TAPS_PER_PHASE = 8,
   parameter int  PHASES         = 2,
   parameter int  CHANNELS       = 2,
   localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
   localparam int PW = (PHASES > 1) ? $clog2(PHASES) : 1,
   localparam int AW = $clog2(PHASES * TAPS_PER_PHASE)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     flush,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic signed [DATA_W-1:0] in_sample,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic signed [DATA_W-1:0] out_sample,
   output logic [CW-1:0]            out_chan,
   output logic [PW-1:0]            out_phase,
   output logic                     busy
`ifdef FIR_INTERP_COEF_WR_EN
   ,input logic                     coef_we,
   input  logic [AW-1:0]            coef_addr,
   input  logic signed [COEF_W-1:0] coef_wdata
`endif
);

   localparam int TW = $clog2(TAPS_PER_PHASE);

   state_t                   state;
   logic signed [DATA_W-1:0] dline [CHANNELS][TAPS_PER_PHASE];
   logic [TW-1:0]            wptr  [CHANNELS];
   logic [TW-1:0]            head, rd_ptr, tap_cnt;
   logic [CW-1:0]            in_chan;
   logic [PW-1:0]            phase;
   logic signed [COEF_W-1:0] coef_def [PHASES][TAPS_PER_PHASE];
   logic signed [COEF_W-1:0] coef     [PHASES][TAPS_PER_PHASE];
   logic signed [DATA_W-1:0] x_cur, mac_y;
   logic signed [COEF_W-1:0] h_cur;

   function automatic logic [TW-1:0] inc_wrap(input logic [TW-1:0] v);
      return (v == TW'(TAPS_PER_PHASE - 1)) ? '0 : v + 1'b1;
   endfunction

   function automatic logic [TW-1:0] dec_wrap(input logic [TW-1:0] v);
      return (v == '0) ? TW'(TAPS_PER_PHASE - 1) : v - 1'b1;
   endfunction

   for (genvar gp = 0; gp < PHASES; gp++) begin : g_ph
      for (genvar gt = 0; gt < TAPS_PER_PHASE; gt++) begin : g_tap
         assign coef_def[gp][gt] = COEF_W'(def_coef(gp, gt, PHASES, COEF_W));
      end
   end

`ifdef FIR_INTERP_COEF_WR_EN
   // Coefficient store: defaults on reset, writable only while idle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         coef <= coef_def;
      end else if (coef_we && state == ST_IDLE) begin
         for (int p = 0; p < PHASES; p++)
            for (int t = 0; t < TAPS_PER_PHASE; t++)
               if (coef_addr == AW'(p * TAPS_PER_PHASE + t)) coef[p][t] <= coef_wdata;
      end
   end
`else
   assign coef = coef_def;
`endif

   assign x_cur = dline[in_chan][rd_ptr];
   assign h_cur = coef[phase][tap_cnt];
   assign busy  = (state != ST_IDLE);

   fir_mac_sat #(
      .DATA_W        (DATA_W),
      .COEF_W        (COEF_W),
      .TAPS_PER_PHASE(TAPS_PER_PHASE)
   ) u_mac (
      .clk  (clk),
      .en   (state == ST_MAC),
      .first(tap_cnt == '0),
      .x    (x_cur),
      .h    (h_cur),
      .y    (mac_y)
   );

   // Control FSM, delay lines and registered output port.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n || flush) begin
         state      <= ST_IDLE;
         in_ready   <= 1'b0;
         out_valid  <= 1'b0;
         out_sample <= '0;
         out_chan   <= '0;
         out_phase  <= '0;
         phase      <= '0;
         in_chan    <= '0;
         tap_cnt    <= '0;
         rd_ptr     <= '0;
         head       <= '0;
         for (int c = 0; c < CHANNELS; c++) begin
            wptr[c] <= '0;
            for (int t = 0; t < TAPS_PER_PHASE; t++) dline[c][t] <= '0;
         end
      end else begin
         case (state)
            ST_IDLE: begin
               in_ready <= 1'b1;
               if (in_ready && in_valid) begin
                  dline[in_chan][wptr[in_chan]] <= in_sample;
                  wptr[in_chan] <= inc_wrap(wptr[in_chan]);
                  head     <= wptr[in_chan];
                  rd_ptr   <= wptr[in_chan];
                  tap_cnt  <= '0;
                  phase    <= '0;
                  in_ready <= 1'b0;
                  state    <= ST_MAC;
               end
            end
            ST_MAC: begin
               tap_cnt <= inc_wrap(tap_cnt);
               rd_ptr  <= dec_wrap(rd_ptr);
               if (tap_cnt == TW'(TAPS_PER_PHASE - 1)) state <= ST_EMIT;
            end
            ST_EMIT: begin
               if (!out_valid) begin
                  out_valid  <= 1'b1;
                  out_sample <= mac_y;
                  out_chan   <= in_chan;
                  out_phase  <= phase;
               end else if (out_ready) begin
                  out_valid <= 1'b0;
                  tap_cnt   <= '0;
                  rd_ptr    <= head;
                  if (phase == PW'(PHASES - 1)) begin
                     phase    <= '0;
                     in_chan  <= (in_chan == CW'(CHANNELS - 1)) ? '0 : in_chan + 1'b1;
                     in_ready <= 1'b1;
                     state    <= ST_IDLE;
                  end else begin
                     phase <= phase + 1'b1;
                     state <= ST_MAC;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fir_interp_poly.sv
// Directed + random bench for fir_interp_poly against a sum-of-products model.
module tb_fir_interp_poly;

   localparam int DATA_W = 24;
   localparam int COEF_W = 16;
   localparam int T      = 8;
   localparam int L      = 2;
   localparam int C      = 2;
   localparam int CW     = (C > 1) ? $clog2(C) : 1;
   localparam int PW     = (L > 1) ? $clog2(L) : 1;
   localparam int AW     = $clog2(L * T);

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              flush = 1'b0;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [DATA_W-1:0] in_sample = '0;
   logic              out_valid;
   logic              out_ready = 1'b1;
   logic [DATA_W-1:0] out_sample;
   logic [CW-1:0]     out_chan;
   logic [PW-1:0]     out_phase;
   logic              busy;
`ifdef FIR_INTERP_COEF_WR_EN
   logic              coef_we = 1'b0;
   logic [AW-1:0]     coef_addr = '0;
   logic [COEF_W-1:0] coef_wdata = '0;
`endif

   fir_interp_poly #(
      .DATA_W(DATA_W), .COEF_W(COEF_W), .TAPS_PER_PHASE(T), .PHASES(L), .CHANNELS(C)
   ) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_sample(in_sample),
      .out_valid(out_valid), .out_ready(out_ready), .out_sample(out_sample),
      .out_chan(out_chan), .out_phase(out_phase), .busy(busy)
`ifdef FIR_INTERP_COEF_WR_EN
      , .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata)
`endif
   );

   always #5 clk = ~clk;

   int     checks = 0;
   int     errors = 0;
   longint hist [C][T];   // hist[ch][k]: sample k inputs back on channel ch
   longint h    [L][T];
   int     mch = 0;       // channel the next accepted sample belongs to
   longint got  [L];      // outputs of the most recent sample, per phase

   task automatic chk(input string tag, input longint obs, input longint exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic model_clear();
      for (int c = 0; c < C; c++)
         for (int k = 0; k < T; k++) hist[c][k] = 0;
      mch = 0;
   endtask

   function automatic longint model_out(input int ch, input int p);
      longint acc, r, maxv, minv;
      acc = 0;
      for (int k = 0; k < T; k++) acc += hist[ch][k] * h[p][k];
      r    = (acc + (longint'(1) <<< (COEF_W - 2))) >>> (COEF_W - 1);
      maxv = (longint'(1) <<< (DATA_W - 1)) - 1;
      minv = -(longint'(1) <<< (DATA_W - 1));
      if (r > maxv) r = maxv;
      if (r < minv) r = minv;
      return r;
   endfunction

   task automatic wait_in_ready();
      int cnt = 0;
      while (!in_ready && cnt < 100) begin @(posedge clk); #1; cnt++; end
      chk("in_ready_wait", longint'(in_ready), 1);
   endtask

   // Push one sample, collect all phases, optionally stalling the first phase.
   task automatic run_sample(input longint s, input bit stall);
      int ch, cnt;
      logic [DATA_W-1:0] hold_s;
      logic [CW-1:0]     hold_c;
      bit                stable;
      wait_in_ready();
      in_valid  = 1'b1;
      in_sample = DATA_W'(s);
      @(posedge clk); #1;
      in_valid  = 1'b0;
      in_sample = DATA_W'($urandom);
      ch = mch;
      for (int k = T - 1; k > 0; k--) hist[ch][k] = hist[ch][k-1];
      hist[ch][0] = s;
      for (int p = 0; p < L; p++) begin
         cnt = 0;
         while (!out_valid && cnt < 100) begin @(posedge clk); #1; cnt++; end
         chk("latency", cnt, T + 1);
         got[p] = longint'($signed(out_sample));
         chk("out_sample", got[p], model_out(ch, p));
         chk("out_chan", longint'(out_chan), ch);
         chk("out_phase", longint'(out_phase), p);
         chk("in_ready_busy", longint'(in_ready), 0);
         if (stall && p == 0) begin
            out_ready = 1'b0;
            hold_s = out_sample;
            hold_c = out_chan;
            stable = 1'b1;
            for (int i = 0; i < 20; i++) begin
               @(posedge clk); #1;
               if (!out_valid || out_sample !== hold_s || out_chan !== hold_c || in_ready)
                  stable = 1'b0;
            end
            chk("stall_stable", longint'(stable), 1);
            out_ready = 1'b1;
         end
         @(posedge clk); #1;
      end
      mch = (mch + 1) % C;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [DATA_W-1:0] rnd;
      int                cnt;
      for (int p = 0; p < L; p++)
         for (int k = 0; k < T; k++) begin
            real v;
            v = 0.0;
            if (k == 0) v = $floor(real'(L - p) / real'(L) * 32768.0 + 0.5);
            if (k == 1) v = $floor(real'(p) / real'(L) * 32768.0 + 0.5);
            if (v >= 32768.0) v = 32767.0;
            h[p][k] = longint'(v);
         end
      model_clear();

      // Reset state.
      #1;
      chk("rst_in_ready", longint'(in_ready), 0);
      chk("rst_out_valid", longint'(out_valid), 0);
      chk("rst_out_sample", longint'(out_sample), 0);
      chk("rst_out_chan", longint'(out_chan), 0);
      chk("rst_out_phase", longint'(out_phase), 0);
      chk("rst_busy", longint'(busy), 0);
      repeat (3) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      chk("post_rst_in_ready", longint'(in_ready), 1);

      // Impulse on ch0, then zeros.
      run_sample(64'sh400000, 1'b0);
      chk("imp_ph0", got[0], 64'sh3FFF80);
      chk("imp_ph1", got[1], 64'sh200000);
      run_sample(0, 1'b0);
      run_sample(0, 1'b0);
      chk("imp2_ph0", got[0], 0);
      chk("imp2_ph1", got[1], 64'sh200000);
      run_sample(0, 1'b0);

      // Step on both channels.
      for (int i = 0; i < 12; i++) run_sample(64'sh100000, 1'b0);
      chk("step_ph0", got[0], 64'sh0FFFE0);
      chk("step_ph1", got[1], 64'sh100000);

      // Full-scale extremes.
      for (int i = 0; i < 4; i++) run_sample(64'sh7FFFFF, 1'b0);
      for (int i = 0; i < 4; i++) run_sample(-64'sh800000, 1'b0);

      // Random samples.
      for (int i = 0; i < 24; i++) begin
         rnd = DATA_W'($urandom);
         run_sample(longint'($signed(rnd)), 1'b0);
      end

      // Backpressure in EMIT.
      rnd = DATA_W'($urandom);
      run_sample(longint'($signed(rnd)), 1'b1);
      run_sample(64'sh123456, 1'b0);

      // Flush in the middle of MAC, then impulse must see no history.
      wait_in_ready();
      in_valid = 1'b1; in_sample = DATA_W'(24'h3ABCDE);
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1 chk("pre_flush_busy", longint'(busy), 1);
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      chk("flush_busy", longint'(busy), 0);
      chk("flush_out_valid", longint'(out_valid), 0);
      model_clear();
      run_sample(64'sh400000, 1'b0);
      chk("flush_imp_ph0", got[0], 64'sh3FFF80);
      chk("flush_imp_ph1", got[1], 64'sh200000);

      // Asynchronous reset while an output is waiting in EMIT.
      run_sample(64'sh2AAAAA, 1'b0);
      wait_in_ready();
      in_valid = 1'b1; in_sample = DATA_W'(24'h555555);
      @(posedge clk); #1;
      in_valid = 1'b0;
      out_ready = 1'b0;
      cnt = 0;
      while (!out_valid && cnt < 100) begin @(posedge clk); #1; cnt++; end
      chk("emit_reached", longint'(out_valid), 1);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_out_valid", longint'(out_valid), 0);
      chk("arst_out_sample", longint'(out_sample), 0);
      chk("arst_out_chan", longint'(out_chan), 0);
      chk("arst_out_phase", longint'(out_phase), 0);
      chk("arst_busy", longint'(busy), 0);
      chk("arst_in_ready", longint'(in_ready), 0);
      @(negedge clk) rst_n = 1'b1;
      out_ready = 1'b1;
      model_clear();
      run_sample(64'sh400000, 1'b0);
      chk("arst_imp_ph0", got[0], 64'sh3FFF80);
      chk("arst_imp_ph1", got[1], 64'sh200000);

`ifdef FIR_INTERP_COEF_WR_EN
      // All taps at max gain: full-scale input must saturate.
      wait_in_ready();
      for (int a = 0; a < L * T; a++) begin
         coef_we = 1'b1; coef_addr = AW'(a); coef_wdata = 16'h7FFF;
         @(posedge clk); #1;
         h[a / T][a % T] = 32767;
      end
      coef_we = 1'b0;
      for (int i = 0; i < 2 * T; i++) run_sample(64'sh7FFFFF, 1'b0);
      chk("sat_pos", got[L-1], 64'sh7FFFFF);
      for (int i = 0; i < 2 * T; i++) run_sample(-64'sh800000, 1'b0);
      chk("sat_neg", got[L-1], -64'sh800000);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
